// File: rtl/road_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | road_pkg                                                             |
// | Shared types and constants for the river-road game blocks.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package road_pkg;

  // Pixel coordinate width used by the video timing and drawers
  localparam int COORD_W = 10;

  // Width of the per-frame overlap accumulator
  localparam int CNT_W = 10;

  // Default crash timing, in frames
  localparam int DEF_FREEZE_FRAMES = 60;
  localparam int DEF_INVULN_FRAMES = 120;

  // Crash sequencer states
  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_FREEZE = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/river_collision_overlap_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | overlap_counter                                                      |
// | Saturating per-frame accumulator of car/river overlap pixels.        |
// | count_next already includes the pixel presented this cycle so the    |
// | frame decision can see a pixel that coincides with frame_tick.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module overlap_counter
  import road_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;

  // Next count including the current pixel, holding at full scale
  always_comb begin
    count_next = count_q;
    if (inc && (count_q != c_MAX)) begin
      count_next = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Accumulate, dropping back to zero on the cycle after a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/river_collision.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | river_collision                                                      |
// | Per-pixel car/river collision detector and crash sequencer. Owns     |
// | lives, the crash freeze, the invulnerability blink window and the    |
// | scroll tick fed back to the river drawer.                            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module river_collision
  import road_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int HIT_THRESHOLD = 4,
  parameter int FREEZE_FRAMES = DEF_FREEZE_FRAMES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_SHIFT   = 3,
  parameter int RIVER_LAT     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               video_on,
  input  logic               frame_tick,
  input  logic               river_on,
  input  logic               car_on,
  input  logic               restart,
  output logic               scroll_tick,
  output logic               crash,
  output logic [1:0]         lives,
  output logic               car_visible,
  output logic               game_over
);

  localparam logic [1:0]       c_LIVES       = 2'(LIVES);
  localparam logic [CNT_W-1:0] c_THRESHOLD   = CNT_W'(HIT_THRESHOLD);
  localparam logic [7:0]       c_FREEZE_LOAD = 8'(FREEZE_FRAMES - 1);
  localparam logic [7:0]       c_INVULN_LOAD = 8'(INVULN_FRAMES - 1);

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       crash_q, crash_d;
  logic       scroll_q, scroll_d;

  logic             w_car_d;
  logic             w_video_d;
  logic             w_overlap;
  logic             w_clear;
  logic             w_hit;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;

  // Coordinates are carried for debug/integration only; the stencils
  // already encode all spatial information this block needs.
  logic unused_inputs;
  assign unused_inputs = ^{pixel_x, pixel_y, w_count};

  // ------------------------------------------------------------------
  // Align car/video stencils with the river ROM read latency
  // ------------------------------------------------------------------
  generate
    if (RIVER_LAT == 0) begin : g_align_wire
      assign w_car_d   = car_on;
      assign w_video_d = video_on;
    end else begin : g_align_pipe
      logic [RIVER_LAT-1:0] car_pipe_q;
      logic [RIVER_LAT-1:0] video_pipe_q;

      // Shift car/video stencils so they meet river_on on the same cycle
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          car_pipe_q   <= '0;
          video_pipe_q <= '0;
        end else begin
          car_pipe_q[0]   <= car_on;
          video_pipe_q[0] <= video_on;
          for (int i = 1; i < RIVER_LAT; i++) begin
            car_pipe_q[i]   <= car_pipe_q[i-1];
            video_pipe_q[i] <= video_pipe_q[i-1];
          end
        end
      end

      assign w_car_d   = car_pipe_q[RIVER_LAT-1];
      assign w_video_d = video_pipe_q[RIVER_LAT-1];
    end
  endgenerate

  assign w_overlap = w_car_d & river_on & w_video_d;

  // The frame that closes on frame_tick is cleared for the next one; a
  // restart also discards whatever accumulated while the game was over.
  assign w_clear = frame_tick | ((state_q == ST_OVER) & restart);

  overlap_counter u_overlap_counter (
    .clk        (clk),
    .reset      (reset),
    .inc        (w_overlap),
    .clear      (w_clear),
    .count      (w_count),
    .count_next (w_count_next)
  );

  assign w_hit = (w_count_next >= c_THRESHOLD);

  // ------------------------------------------------------------------
  // Crash sequencer
  // ------------------------------------------------------------------

  // State, lives, frame counter and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLAY;
      lives_q     <= c_LIVES;
      frame_cnt_q <= '0;
      crash_q     <= 1'b0;
      scroll_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      crash_q     <= crash_d;
      scroll_q    <= scroll_d;
    end
  end

  // Next-state: frame-rate transitions, except restart which is immediate
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    crash_d     = 1'b0;
    // Scroll decision uses the pre-update state so a crashing frame scrolls
    scroll_d    = frame_tick & ((state_q == ST_PLAY) | (state_q == ST_INVULN));

    case (state_q)
      ST_PLAY: begin
        if (frame_tick && w_hit) begin
          crash_d = 1'b1;
          if (lives_q > 2'd1) begin
            lives_d     = lives_q - 2'd1;
            state_d     = ST_FREEZE;
            frame_cnt_d = c_FREEZE_LOAD;
          end else begin
            lives_d     = 2'd0;
            state_d     = ST_OVER;
            frame_cnt_d = '0;
          end
        end
      end
      ST_FREEZE: begin
        if (frame_tick) begin
          if (frame_cnt_q == 8'd0) begin
            state_d     = ST_INVULN;
            frame_cnt_d = c_INVULN_LOAD;
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
      end
      ST_INVULN: begin
        if (frame_tick) begin
          if (frame_cnt_q == 8'd0) begin
            state_d     = ST_PLAY;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (restart) begin
          lives_d     = c_LIVES;
          state_d     = ST_PLAY;
          frame_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // Outputs decoded from the current state; the car blinks while invulnerable
  always_comb begin
    car_visible = 1'b1;
    game_over   = 1'b0;
    case (state_q)
      ST_INVULN: car_visible = ~frame_cnt_q[BLINK_SHIFT];
      ST_OVER: begin
        car_visible = 1'b0;
        game_over   = 1'b1;
      end
      default: begin
        car_visible = 1'b1;
      end
    endcase
  end

  assign scroll_tick = scroll_q;
  assign crash       = crash_q;
  assign lives       = lives_q;

endmodule
`default_nettype wire

// File: tb/tb_river_collision.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_river_collision                                                   |
// | Randomised bench with a frame-level game model and a scoreboard.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_river_collision;

  // Game rules as the model understands them
  localparam int T_LIVES   = 3;
  localparam int T_THR     = 4;
  localparam int T_FREEZE  = 60;
  localparam int T_INVULN  = 120;
  localparam int T_BLINK   = 8;   // frames per blink half-period
  localparam int FRAME_LEN = 20;
  localparam int TICK_POS  = 18;

  localparam int M_PLAY   = 0;
  localparam int M_FREEZE = 1;
  localparam int M_INVULN = 2;
  localparam int M_OVER   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       video_on = 1'b0;
  logic       frame_tick = 1'b0;
  logic       river_on = 1'b0;
  logic       car_on = 1'b0;
  logic       restart = 1'b0;
  logic       scroll_tick;
  logic       crash;
  logic [1:0] lives;
  logic       car_visible;
  logic       game_over;

  river_collision dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .frame_tick  (frame_tick),
    .river_on    (river_on),
    .car_on      (car_on),
    .restart     (restart),
    .scroll_tick (scroll_tick),
    .crash       (crash),
    .lives       (lives),
    .car_visible (car_visible),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit crash;
    bit scroll;
    int lives;
    bit vis;
    bit over;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state
  int m_mode  = M_PLAY;
  int m_lives = T_LIVES;
  int m_left  = 0;      // frames remaining in FREEZE / INVULN
  int m_acc   = 0;      // overlap pixels gathered so far this frame
  bit m_pc    = 0;      // car/video seen one cycle earlier
  bit m_pv    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_visible();
    if (m_mode == M_OVER)   return 1'b0;
    if (m_mode == M_INVULN) return (((m_left - 1) / T_BLINK) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic push_exp(input bit cr, input bit scr);
    exp_t e;
    e.crash  = cr;
    e.scroll = scr;
    e.lives  = m_lives;
    e.vis    = model_visible();
    e.over   = (m_mode == M_OVER);
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_mode = M_PLAY; m_lives = T_LIVES; m_left = 0; m_acc = 0; m_pc = 0; m_pv = 0;
  endtask

  // One pixel-clock of game rules: a pixel overlaps when the river this
  // cycle meets the car/video of the previous cycle (ROM latency of 1).
  task automatic model_step(input bit c, input bit v, input bit r, input bit t, input bit rs);
    int ov;
    int total;
    bit scr;
    bit cr;
    ov   = (m_pc && m_pv && r) ? 1 : 0;
    m_pc = c;
    m_pv = v;
    if (rs && m_mode == M_OVER) begin
      m_lives = T_LIVES; m_mode = M_PLAY; m_acc = 0;
      push_exp(0, 0);
    end else if (t) begin
      total = m_acc + ov;
      scr   = (m_mode == M_PLAY) || (m_mode == M_INVULN);
      cr    = 0;
      if (m_mode == M_PLAY) begin
        if (total >= T_THR) begin
          cr = 1;
          m_lives--;
          if (m_lives == 0) m_mode = M_OVER;
          else begin m_mode = M_FREEZE; m_left = T_FREEZE; end
        end
      end else if (m_mode == M_FREEZE) begin
        m_left--;
        if (m_left == 0) begin m_mode = M_INVULN; m_left = T_INVULN; end
      end else if (m_mode == M_INVULN) begin
        m_left--;
        if (m_left == 0) m_mode = M_PLAY;
      end
      m_acc = 0;
      push_exp(cr, scr);
    end else begin
      m_acc += ov;
      if (rs) push_exp(0, 0);
    end
  endtask

  task automatic drive(input bit c, input bit v, input bit r, input bit t, input bit rs);
    @(posedge clk); #1;
    car_on = c; video_on = v; river_on = r; frame_tick = t; restart = rs;
    pixel_x = 10'($urandom_range(0, 639));
    pixel_y = 10'($urandom_range(0, 479));
    model_step(c, v, r, t, rs);
  endtask

  // Frame with exactly n in-frame overlaps, optionally one on the tick
  // cycle and/or one on the cycle right after the tick.
  task automatic run_frame_exact(input int n, input bit on_tick, input bit after_tick);
    bit c[FRAME_LEN];
    bit v[FRAME_LEN];
    bit r[FRAME_LEN];
    bit want[FRAME_LEN];
    for (int i = 0; i < FRAME_LEN; i++) want[i] = 0;
    for (int k = 0; k < n; k++) want[2*k+1] = 1;
    if (on_tick)    want[TICK_POS]   = 1;
    if (after_tick) want[TICK_POS+1] = 1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i + 1 < FRAME_LEN && want[i+1]) begin c[i] = 1; v[i] = 1; end
      else begin c[i] = 1'($urandom % 2); v[i] = 1'($urandom % 2); end
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (want[i])                       r[i] = 1;
      else if (i == 0)                   r[i] = 0;
      else if (c[i-1] && v[i-1])         r[i] = 0;
      else                               r[i] = 1'($urandom % 2);
    end
    for (int i = 0; i < FRAME_LEN; i++) drive(c[i], v[i], r[i], i == TICK_POS, 0);
  endtask

  task automatic run_frame_rand(input int pct);
    for (int i = 0; i < FRAME_LEN; i++)
      drive(($urandom % 100) < pct, ($urandom % 100) < pct, ($urandom % 100) < pct,
            i == TICK_POS, 0);
  endtask

  // Ride out FREEZE with random traffic, INVULN with solid overlap
  task automatic settle();
    int guard;
    guard = 0;
    while ((m_mode == M_FREEZE || m_mode == M_INVULN) && guard < 400) begin
      run_frame_rand(m_mode == M_FREEZE ? 60 : 100);
      guard++;
    end
  endtask

  task automatic do_restart();
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_crash"},  int'(crash),       0);
    check({tag, "_scroll"}, int'(scroll_tick), 0);
    check({tag, "_lives"},  int'(lives),       T_LIVES);
    check({tag, "_vis"},    int'(car_visible), 1);
    check({tag, "_over"},   int'(game_over),   0);
  endtask

  // Monitor: an input event (tick/restart) at an edge must be answered
  // by the outputs right after that edge; pulses are otherwise low.
  bit ev_q = 1'b0;
  always @(posedge clk) ev_q <= frame_tick | restart;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (ev_q) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty actual=event expected=queued response at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("crash",       int'(crash),       int'(e.crash));
          check("scroll_tick", int'(scroll_tick), int'(e.scroll));
          check("lives",       int'(lives),       e.lives);
          check("car_visible", int'(car_visible), int'(e.vis));
          check("game_over",   int'(game_over),   int'(e.over));
        end
      end else begin
        check("idle_pulses", int'({crash, scroll_tick}), 0);
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Car never on water: scroll every frame, no crash
    repeat (10) run_frame_exact(0, 0, 0);

    // Threshold: 3 pixels safe, 4 pixels crash
    run_frame_exact(3, 0, 0);
    run_frame_exact(4, 0, 0);
    settle();

    // Second and third hits end the game
    run_frame_exact(5, 0, 0);
    settle();
    run_frame_exact(4, 0, 0);
    repeat (3) run_frame_rand(50);
    do_restart();

    // Pixel coincident with frame_tick belongs to the closing frame
    run_frame_exact(3, 1, 0);
    settle();

    // Pixel right after frame_tick belongs to the next frame
    run_frame_exact(3, 0, 1);
    run_frame_exact(3, 0, 0);

    // Asynchronous reset partway through FREEZE frame 30
    repeat (29) run_frame_rand(50);
    repeat (3) drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_frame_exact(0, 0, 0);

    // Random traffic across all states
    for (int f = 0; f < 40; f++) begin
      if (m_mode == M_OVER && ($urandom % 3) == 0) do_restart();
      else run_frame_rand(($urandom % 2) ? 5 : 30);
    end

    repeat (4) drive(0, 0, 0, 0, 0);
    check("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/river_collision.md
# river_collision

Per-pixel collision and crash sequencer that consumes the river stencil (`river_on` from `river_drawer`) and the player-car stencil, and decides once per frame whether the car has hit water. It owns lives, the crash freeze and the post-crash invulnerability window. It also produces the scroll tick fed back to `river_drawer.update_signal`, so the river stops scrolling while the car is frozen.

## Interface
- `LIVES`, 3: lives at reset and restart; at most 3.
- `HIT_THRESHOLD`, 4: minimum overlapping pixels in one frame for that frame to count as a hit.
- `FREEZE_FRAMES`, 60: frames spent frozen after a crash.
- `INVULN_FRAMES`, 120: frames of invulnerability after the freeze.
- `BLINK_SHIFT`, 3: the car blinks with a period of 2^(BLINK_SHIFT+1) frames.
- `RIVER_LAT`, 1: cycles by which `river_on` lags `pixel_x`/`pixel_y`. This is the ROM read latency.
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high.
- `pixel_x`, `pixel_y` in 10 each: current pixel coordinates.
- `video_on` in 1: high in the visible area, aligned with `pixel_x`/`pixel_y`.
- `frame_tick` in 1: one-cycle pulse per frame, asserted only in vertical blanking.
- `river_on` in 1: river stencil, delayed by RIVER_LAT.
- `car_on` in 1: car stencil, aligned with `pixel_x`/`pixel_y`.
- `restart` in 1: level, sampled only in OVER.
- `scroll_tick` out 1: drives `river_drawer.update_signal`.
- `crash` out 1: one-cycle pulse.
- `lives` out 2: remaining lives.
- `car_visible` out 1: gate for the car sprite.
- `game_over` out 1: high in OVER.

## Operation
- **Alignment:** `car_on` and `video_on` pass through a RIVER_LAT-deep shift register. `overlap = car_d & river_on & video_d`.
- **Overlap counter:**
  - 10 bits, saturating at 1023, and increments on `overlap`.
  - When `overlap` and `frame_tick` fall in the same cycle, that pixel counts toward the frame being closed.
  - The counter clears to 0 on the cycle after `frame_tick`.
- **Frame hit:** `hit = (count_incl_current >= HIT_THRESHOLD)`, evaluated only on `frame_tick`.
- **Frame counter:** 8 bits. It is loaded on every state transition and counts down on `frame_tick`.
- **State machine** (transitions and counting happen only on `frame_tick`, except `restart`):
  - PLAY, hit, lives > 1: lives−1, `crash` pulse, go to FREEZE, frame counter = FREEZE_FRAMES−1.
  - PLAY, hit, lives == 1: lives = 0, `crash` pulse, go to OVER.
  - PLAY, no hit: stay in PLAY.
  - FREEZE: hits ignored. At counter 0 go to INVULN, frame counter = INVULN_FRAMES−1. Otherwise decrement.
  - INVULN: hits ignored. At counter 0 go to PLAY. Otherwise decrement.
  - OVER: stays in OVER. `restart` high in any cycle reloads lives = LIVES, clears the overlap counter and goes to PLAY.
- **scroll_tick:** registered `frame_tick & (state==PLAY | state==INVULN)`, evaluated against the state before the update. The tick that causes a crash still scrolls.
- **car_visible:**
  - 1 in PLAY and FREEZE.
  - In INVULN, equals `~frame_cnt[BLINK_SHIFT]`.
  - 0 in OVER.
- **game_over:** equals `state==OVER`.
- **Reset:** state = PLAY, lives = LIVES, counters = 0, alignment pipe = 0. Outputs at reset: `scroll_tick` 0, `crash` 0, `lives` LIVES, `car_visible` 1, `game_over` 0.

## Timing
- Let `frame_tick` be asserted in cycle t:
  - `crash`, `scroll_tick`, the new `lives`, the new state and `game_over` are all valid in cycle t+1.
  - `crash` and `scroll_tick` last exactly one cycle.
- The overlap counter is cleared in cycle t+1. Pixels arriving in cycle t+1 and later count toward the next frame.
- `restart` in OVER in cycle t gives state = PLAY and `lives` = LIVES in cycle t+1. `restart` is ignored in any other state.
- Asynchronous `reset` mid-frame or mid-FREEZE returns to the reset values immediately. No pulse is emitted.
- The end-to-end overlap pipeline latency is RIVER_LAT cycles. With RIVER_LAT = 0 the alignment pipe is a wire.

## Structure
- Shared package `road_pkg`:
  - state encoding: PLAY = 0, FREEZE = 1, INVULN = 2, OVER = 3;
  - the 10-bit coordinate width;
  - default frame constants (FREEZE_FRAMES, INVULN_FRAMES).
- One sub-module, `overlap_counter`: the saturating per-frame accumulator, with ports `clk`, `reset`, `inc`, `clear`, `count`, `count_next`.
- The FSM, lives register, frame counter and alignment pipe live in the top level.

## Test plan
- Car fully outside the river for 10 frames -> `scroll_tick` pulses 10 times, `crash` never pulses, `lives` stays 3.
- 3 overlapping pixels in a frame -> no crash. 4 pixels -> `crash` in the cycle after `frame_tick`, `lives` = 2, no `scroll_tick` for the next 60 frames.
- After the freeze, INVULN with continuous overlap -> no crash for 120 frames. `car_visible` toggles every 8 frames. The next hit after INVULN gives `lives` = 1.
- Three consecutive hits -> `game_over` = 1, `car_visible` = 0, `scroll_tick` stops. `restart` pulse -> `lives` = 3 and PLAY the next cycle.
- Overlap pixel coincident with `frame_tick` when the count is already 3 -> that frame counts as a hit. Overlap pixel at t+1 -> counted in the next frame.
- `reset` asserted during FREEZE frame 30 -> immediate PLAY with `lives` = 3. On deassert, `scroll_tick` follows the next `frame_tick`.
